// File: rtl/osd_egress_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_egress_arbiter_if
// Description : Flit bundle between N debug flit sources, the egress arbiter
//               and the downstream debug_out link.
//                 in_valid/in_last/in_data : per-source flits (source side)
//                 in_ready                 : per-source ready (arbiter side)
//                 out_valid/out_last/
//                 out_data                 : arbitrated egress flit
//                 out_ready                : downstream ready
//               master : environment side (sources + downstream sink)
//               slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface osd_egress_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0][15:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_last;
  logic [15:0]        out_data;
  logic               out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );
endinterface
`default_nettype wire

// File: rtl/osd_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : osd_egress_arbiter
// Description : Packet-atomic round-robin arbiter sharing one debug egress
//               link among N flit sources. Zero-latency combinational data
//               path; only the state, the locked source and the last granted
//               source are registered.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               io_bus     - flit bundle (slave modport)
//               i_stall_in - holds off new packets from STALL_MASK sources
//               o_grant    - index of the currently selected source
//               o_busy     - high while a packet is locked to a source
// Revision    : 1.0 - initial release
// ============================================================================
module osd_egress_arbiter #(
  parameter int           N          = 2,
  parameter logic [N-1:0] STALL_MASK = '0,
  localparam int          GW         = $clog2(N)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  osd_egress_arbiter_if.slave io_bus,
  input  wire logic          i_stall_in,
  output logic [GW-1:0]      o_grant,
  output logic               o_busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_lock;
  logic [GW-1:0] w_lock_nxt;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] w_last_grant_nxt;
  logic [1:0]    r_rst_sync;

  logic          w_rst_ok;
  logic [N-1:0]  w_elig;
  logic [GW-1:0] w_sel;
  logic          w_any;
  logic [GW-1:0] w_cur;
  logic          w_present;
  logic          w_xfer;
  logic [N-1:0]  w_in_ready;

  // Reset asserts immediately but releases two clocks after rst_n rises, so
  // the first decision after reset is taken on a clean edge. Outputs stay
  // silent until the release has propagated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_ok = r_rst_sync[1];

  // Sources in the stall mask may not open a new packet while stalled.
  assign w_elig = io_bus.in_valid & ~(STALL_MASK & {N{i_stall_in}}) & {N{w_rst_ok}};

  // Round-robin pick: scan from last_grant+1 with wrap. The loop walks from
  // the farthest candidate to the nearest so the nearest eligible one wins.
  always_comb begin
    w_sel = r_last_grant;
    w_any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (w_elig[(int'(r_last_grant) + k) % N]) begin
        w_sel = GW'((int'(r_last_grant) + k) % N);
        w_any = 1'b1;
      end
    end
  end

  // Data path: the locked source in LOCKED, the round-robin pick in IDLE.
  // A bubble from the locked source shows as out_valid=0 without switching.
  always_comb begin
    w_in_ready = '0;
    if (r_state == S_LOCKED) begin
      w_cur     = r_lock;
      w_present = io_bus.in_valid[r_lock] & w_rst_ok;
      if (w_rst_ok) begin
        w_in_ready[r_lock] = io_bus.out_ready;
      end
    end else begin
      w_cur     = w_sel;
      w_present = w_any;
      if (w_any) begin
        w_in_ready[w_sel] = io_bus.out_ready;
      end
    end
  end

  assign w_xfer           = w_present & io_bus.out_ready;
  assign io_bus.out_valid = w_present;
  assign io_bus.out_last  = io_bus.in_last[w_cur];
  assign io_bus.out_data  = io_bus.in_data[w_cur];
  assign io_bus.in_ready  = w_in_ready;

  // In IDLE w_sel already falls back to last_grant when nothing is eligible.
  assign o_grant = w_cur;
  assign o_busy  = (r_state == S_LOCKED);

  // A presented flit that is not finished this cycle (multi-flit start or
  // back-pressured) locks the source, so a stall or a higher-priority source
  // appearing later can never change a flit already on the link.
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_nxt       = r_lock;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (w_present) begin
          if (w_xfer && io_bus.in_last[w_sel]) begin
            w_last_grant_nxt = w_sel;
          end else begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = w_sel;
          end
        end
      end
      S_LOCKED: begin
        if (w_xfer && io_bus.in_last[r_lock]) begin
          w_state_nxt      = S_IDLE;
          w_last_grant_nxt = r_lock;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lock       <= '0;
      r_last_grant <= GW'(N - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_lock       <= w_lock_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osd_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_egress_arbiter
// Description : Directed bench for osd_egress_arbiter. A two-source instance
//               (stall mask 'b10) covers reset, priority start, atomicity,
//               back-pressure, stall, bubble and mid-packet reset; a
//               four-source instance covers round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_egress_arbiter;

  logic clk;
  logic rst_n;
  logic stall2;
  logic stall4;
  logic o_busy2;
  logic o_busy4;
  logic [0:0] o_grant2;
  logic [1:0] o_grant4;

  int n_vec;
  int n_err;

  osd_egress_arbiter_if #(.N(2)) if2 ();
  osd_egress_arbiter_if #(.N(4)) if4 ();

  osd_egress_arbiter #(.N(2), .STALL_MASK(2'b10)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_bus     (if2),
    .i_stall_in (stall2),
    .o_grant    (o_grant2),
    .o_busy     (o_busy2)
  );

  osd_egress_arbiter #(.N(4), .STALL_MASK(4'b0000)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_bus     (if4),
    .i_stall_in (stall4),
    .o_grant    (o_grant4),
    .o_busy     (o_busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output check of the two-source instance; last/data are only
  // meaningful when a flit is presented.
  task automatic chk2(input string tag, input logic v, input logic l, input logic [15:0] d,
                      input logic [1:0] rdy, input logic g, input logic b);
    chk({tag, ".valid"}, 32'(if2.out_valid), 32'(v));
    if (v) begin
      chk({tag, ".last"}, 32'(if2.out_last), 32'(l));
      chk({tag, ".data"}, 32'(if2.out_data), 32'(d));
    end
    chk({tag, ".ready"}, 32'(if2.in_ready), 32'(rdy));
    chk({tag, ".grant"}, 32'(o_grant2), 32'(g));
    chk({tag, ".busy"},  32'(o_busy2),  32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src2(input logic [1:0] v, input logic l0, input logic [15:0] d0,
                      input logic l1, input logic [15:0] d1);
    if2.in_valid   = v;
    if2.in_last[0] = l0;
    if2.in_data[0] = d0;
    if2.in_last[1] = l1;
    if2.in_data[1] = d1;
  endtask

  // Protocol monitors: one-hot-or-zero ready and flit stability under
  // back-pressure, for both instances.
  logic        p2_hold, p4_hold;
  logic        p2_last, p4_last;
  logic [15:0] p2_data, p4_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      p2_hold = 1'b0;
      p4_hold = 1'b0;
    end else begin
      n_vec++;
      assert ($onehot0(if2.in_ready)) else begin
        n_err++;
        $error("FAIL onehot2 observed=%0h expected=onehot0", if2.in_ready);
      end
      n_vec++;
      assert ($onehot0(if4.in_ready)) else begin
        n_err++;
        $error("FAIL onehot4 observed=%0h expected=onehot0", if4.in_ready);
      end
      if (p2_hold) begin
        n_vec++;
        assert (if2.out_valid === 1'b1 && if2.out_last === p2_last && if2.out_data === p2_data) else begin
          n_err++;
          $error("FAIL stable2 observed=%0h/%0h/%0h expected=1/%0h/%0h",
                 if2.out_valid, if2.out_last, if2.out_data, p2_last, p2_data);
        end
      end
      if (p4_hold) begin
        n_vec++;
        assert (if4.out_valid === 1'b1 && if4.out_last === p4_last && if4.out_data === p4_data) else begin
          n_err++;
          $error("FAIL stable4 observed=%0h/%0h/%0h expected=1/%0h/%0h",
                 if4.out_valid, if4.out_last, if4.out_data, p4_last, p4_data);
        end
      end
      p2_hold = if2.out_valid && !if2.out_ready;
      p2_last = if2.out_last;
      p2_data = if2.out_data;
      p4_hold = if4.out_valid && !if4.out_ready;
      p4_last = if4.out_last;
      p4_data = if4.out_data;
    end
  end

  int ph[4];
  int pk[4];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall2 = 1'b0;
    stall4 = 1'b0;
    if2.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    if4.in_valid = '0;
    if4.in_last  = '0;
    if4.in_data  = '0;
    src2(2'b01, 1'b1, 16'h0001, 1'b1, 16'h1001);

    // Reset: outputs silent even with a source valid; last_grant = N-1.
    @(negedge clk);
    chk2("rst", 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("rst4.valid", 32'(if4.out_valid), 32'd0);
    chk("rst4.grant", 32'(o_grant4), 32'd3);
    tick(); rst_n = 1'b1; src2(2'b00, 1'b1, 16'h0001, 1'b1, 16'h1001);
    tick(); tick(); tick();

    // Priority start: source 0 then source 1, back to back.
    src2(2'b11, 1'b1, 16'h0001, 1'b1, 16'h1001);
    @(negedge clk); chk2("prio0", 1'b1, 1'b1, 16'h0001, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b10;
    @(negedge clk); chk2("prio1", 1'b1, 1'b1, 16'h1001, 2'b10, 1'b1, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Atomicity: 4-flit packet from source 1, source 0 waits.
    src2(2'b10, 1'b1, 16'h0002, 1'b0, 16'hA000);
    @(negedge clk); chk2("atom0", 1'b1, 1'b0, 16'hA000, 2'b10, 1'b1, 1'b0);
    tick(); src2(2'b11, 1'b1, 16'h0002, 1'b0, 16'hA001);
    @(negedge clk); chk2("atom1", 1'b1, 1'b0, 16'hA001, 2'b10, 1'b1, 1'b1);
    tick(); src2(2'b11, 1'b1, 16'h0002, 1'b0, 16'hA002);
    @(negedge clk); chk2("atom2", 1'b1, 1'b0, 16'hA002, 2'b10, 1'b1, 1'b1);
    tick(); src2(2'b11, 1'b1, 16'h0002, 1'b1, 16'hA003);
    @(negedge clk); chk2("atom3", 1'b1, 1'b1, 16'hA003, 2'b10, 1'b1, 1'b1);
    tick(); if2.in_valid = 2'b01;
    @(negedge clk); chk2("atom4", 1'b1, 1'b1, 16'h0002, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Back-pressure: source 1 held 5 cycles, source 0 arrives in cycle 2.
    if2.out_ready = 1'b0;
    src2(2'b10, 1'b1, 16'h0003, 1'b1, 16'hB0B0);
    @(negedge clk); chk2("bp0", 1'b1, 1'b1, 16'hB0B0, 2'b00, 1'b1, 1'b0);
    tick();
    @(negedge clk); chk2("bp1", 1'b1, 1'b1, 16'hB0B0, 2'b00, 1'b1, 1'b1);
    tick(); if2.in_valid = 2'b11;
    @(negedge clk); chk2("bp2", 1'b1, 1'b1, 16'hB0B0, 2'b00, 1'b1, 1'b1);
    tick();
    @(negedge clk); chk2("bp3", 1'b1, 1'b1, 16'hB0B0, 2'b00, 1'b1, 1'b1);
    tick();
    @(negedge clk); chk2("bp4", 1'b1, 1'b1, 16'hB0B0, 2'b00, 1'b1, 1'b1);
    tick(); if2.out_ready = 1'b1;
    @(negedge clk); chk2("bp5", 1'b1, 1'b1, 16'hB0B0, 2'b10, 1'b1, 1'b1);
    tick(); if2.in_valid = 2'b01;
    @(negedge clk); chk2("bp6", 1'b1, 1'b1, 16'h0003, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Stall: raised mid-packet of source 1; its next packet waits.
    src2(2'b10, 1'b1, 16'h0004, 1'b0, 16'hC000);
    @(negedge clk); chk2("st0", 1'b1, 1'b0, 16'hC000, 2'b10, 1'b1, 1'b0);
    tick(); stall2 = 1'b1; src2(2'b11, 1'b1, 16'h0004, 1'b0, 16'hC001);
    @(negedge clk); chk2("st1", 1'b1, 1'b0, 16'hC001, 2'b10, 1'b1, 1'b1);
    tick(); src2(2'b11, 1'b1, 16'h0004, 1'b1, 16'hC002);
    @(negedge clk); chk2("st2", 1'b1, 1'b1, 16'hC002, 2'b10, 1'b1, 1'b1);
    tick(); src2(2'b11, 1'b1, 16'h0004, 1'b1, 16'hC100);
    @(negedge clk); chk2("st3", 1'b1, 1'b1, 16'h0004, 2'b01, 1'b0, 1'b0);
    tick(); src2(2'b11, 1'b1, 16'h0005, 1'b1, 16'hC100);
    @(negedge clk); chk2("st4", 1'b1, 1'b1, 16'h0005, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b10;
    @(negedge clk); chk2("st5", 1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
    tick(); stall2 = 1'b0;
    @(negedge clk); chk2("st6", 1'b1, 1'b1, 16'hC100, 2'b10, 1'b1, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Bubble: source 0 drops valid for 2 cycles while locked.
    src2(2'b11, 1'b0, 16'hD000, 1'b1, 16'hE000);
    @(negedge clk); chk2("bub0", 1'b1, 1'b0, 16'hD000, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b10;
    @(negedge clk); chk2("bub1", 1'b0, 1'b0, 16'h0, 2'b01, 1'b0, 1'b1);
    tick();
    @(negedge clk); chk2("bub2", 1'b0, 1'b0, 16'h0, 2'b01, 1'b0, 1'b1);
    tick(); src2(2'b11, 1'b1, 16'hD001, 1'b1, 16'hE000);
    @(negedge clk); chk2("bub3", 1'b1, 1'b1, 16'hD001, 2'b01, 1'b0, 1'b1);
    tick(); if2.in_valid = 2'b10;
    @(negedge clk); chk2("bub4", 1'b1, 1'b1, 16'hE000, 2'b10, 1'b1, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Reset mid-packet: lock dropped, source 0 has priority afterwards.
    src2(2'b10, 1'b1, 16'h0006, 1'b0, 16'hF000);
    @(negedge clk); chk2("mrst0", 1'b1, 1'b0, 16'hF000, 2'b10, 1'b1, 1'b0);
    tick(); rst_n = 1'b0;
    @(negedge clk); chk2("mrst1", 1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    tick(); rst_n = 1'b1; if2.in_valid = 2'b00;
    tick(); tick(); tick();
    src2(2'b11, 1'b1, 16'h0006, 1'b1, 16'hF000);
    @(negedge clk); chk2("mrst2", 1'b1, 1'b1, 16'h0006, 2'b01, 1'b0, 1'b0);
    tick(); if2.in_valid = 2'b10;
    @(negedge clk); chk2("mrst3", 1'b1, 1'b1, 16'hF000, 2'b10, 1'b1, 1'b0);
    tick(); if2.in_valid = 2'b00;

    // Round-robin, N=4: every source always has a 2-flit packet ready.
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0;
      pk[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) begin
        if4.in_valid[i] = 1'b1;
        if4.in_last[i]  = (ph[i] == 1);
        if4.in_data[i]  = {4'(i), 4'(pk[i]), 8'(ph[i])};
      end
      @(negedge clk);
      chk($sformatf("rr%0d.grant", c), 32'(o_grant4), 32'((c / 2) % 4));
      chk($sformatf("rr%0d.data", c), 32'(if4.out_data),
          32'({4'((c / 2) % 4), 4'(c / 8), 8'(c % 2)}));
      chk($sformatf("rr%0d.last", c), 32'(if4.out_last), 32'(c % 2));
      chk($sformatf("rr%0d.busy", c), 32'(o_busy4), 32'(c % 2));
      for (int i = 0; i < 4; i++) begin
        if (if4.in_valid[i] && if4.in_ready[i]) begin
          if (ph[i] == 1) begin
            ph[i] = 0;
            pk[i] = pk[i] + 1;
          end else begin
            ph[i] = 1;
          end
        end
      end
      tick();
    end
    if4.in_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/osd_egress_arbiter.md
# osd_egress_arbiter

Packet-atomic round-robin arbiter that shares one debug egress link (`debug_out` of a debug module) among N flit sources: register-access responses, event/trace packets, and other module-generated traffic. It sits between the sources and the `debug_out`/`debug_out_ready` pair and replaces a fixed two-input mux when a module has more than one packet generator. Once a packet has started, it is never interleaved with another. A global stall input can hold off new packets from selected sources without breaking packets in flight.

## Interface
- `N`, default 2: number of input sources; legal range 2..8.
- `STALL_MASK`, default `'0`: N-bit mask. When bit i is set, input i cannot start a new packet while `stall_in` is high.
- `clk`, input, 1 bit: clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `in_flit`, input, N x `dii_flit`: source flits. Each flit carries `valid`, `last` and `data[15:0]`.
- `in_ready`, output, N bits: per-source ready.
- `out_flit`, output, `dii_flit`: arbitrated egress flit.
- `out_ready`, input, 1 bit: downstream ready.
- `stall_in`, input, 1 bit: blocks new packets from sources in `STALL_MASK`.
- `grant`, output, `$clog2(N)` bits: index of the currently selected source, for debug.
- `busy`, output, 1 bit: high while a packet is locked to a source.

## Operation
- A transfer occurs on an input or the output when `valid && ready` in a cycle.
- Eligible set `E` is bit i = `in_flit[i].valid && !(stall_in && STALL_MASK[i])`.
- The block has two states, IDLE and LOCKED.
- **IDLE:**
  - `sel` = first set bit of `E`, scanning from `last_grant+1` upward with modulo-N wrap.
  - If `E` is zero, `out_flit.valid` = 0 and all `in_ready` = 0.
  - Otherwise `out_flit` = `in_flit[sel]`, `in_ready[sel]` = `out_ready`, and all other `in_ready` = 0.
- **IDLE → LOCKED** (latch `lock` = `sel`) in either case:
  - a transfer with `last` = 0;
  - `out_flit.valid` = 1 and `out_ready` = 0. A presented flit must not change until accepted.
- **IDLE**, transfer with `last` = 1: stay in IDLE and set `last_grant` ← `sel`. A single-flit packet costs one cycle.
- **LOCKED:**
  - `out_flit` = `in_flit[lock]` and `in_ready[lock]` = `out_ready`; all others 0.
  - `stall_in` is ignored, so an in-flight packet always completes.
- **LOCKED → IDLE** on a transfer with `last` = 1; set `last_grant` ← `lock`.
- **LOCKED** with a source bubble (`in_flit[lock].valid` = 0): `out_flit.valid` = 0, stay LOCKED, and do not switch sources.
- `grant` = `lock` in LOCKED, `sel` in IDLE. When IDLE with `E` = 0, `grant` = `last_grant`.
- `busy` = 1 in LOCKED only.
- The block never modifies `data` or `last`.

## Timing
- Combinational data path from input to output: zero-cycle latency, no buffering. Only the state, `lock` and `last_grant` are registered.
- Reset values (async assert, sync deassert inside the block):
  - state = IDLE;
  - `last_grant` = N-1, so input 0 has first priority;
  - `lock` = 0.
- While `rst_n` = 0: `out_flit.valid` = 0 and all `in_ready` = 0, regardless of inputs.
- Throughput: one flit per cycle. No idle cycle between back-to-back packets from different sources.
- Fairness: with all N sources continuously valid, each source gets exactly one packet per N packets.
- Simultaneous events:
  - `stall_in` rising while a masked source is LOCKED: the packet finishes.
  - `stall_in` while in IDLE with a masked flit already presented (stalled state is LOCKED) also finishes.
- Reset mid-packet: the lock is dropped, and the next packet after reset starts from source 0 priority. Sources are responsible for their own reset.
- Assertions, required in the bench:
  - `out_flit` stable while `valid && !out_ready`;
  - at most one `in_ready` high per cycle.

## Test plan
- **Reset, then priority start:** reset, then sources 0 and 1 each present a 1-flit packet, `out_ready` = 1. Required: source 0 in cycle 0, source 1 in cycle 1, no gap.
- **Atomicity:**
  - Stimulus: source 1 sends a 4-flit packet (0xA000..0xA003) while source 0 presents continuously.
  - Required: out carries 0xA000..0xA003 contiguously, then source 0; `busy` = 1 for exactly 3 cycles.
- **Backpressure stability:**
  - Stimulus: `out_ready` = 0 for 5 cycles with source 1 presented, source 0 becomes valid in cycle 2.
  - Required: `out_flit` = source 1's flit unchanged for all 5 cycles, then accepted.
- **Round-robin, N=4:** all sources continuously send 2-flit packets. Required: grant order 0,1,2,3,0,... across 8 packets.
- **Stall:**
  - Stimulus: `STALL_MASK` = 'b10. Raise `stall_in` mid-way through source 1's 3-flit packet, and present source 1 again.
  - Required: the current packet completes; the next source 1 packet waits; source 0 packets proceed; source 1 resumes the cycle after `stall_in` falls.
- **Bubble:**
  - Stimulus: source 0 drops `valid` for 2 cycles mid-packet while source 1 is valid.
  - Required: `out_flit.valid` = 0 for 2 cycles, no switch to source 1 before source 0's `last`.
